// File: rtl/oc8051_op_select_pri.sv
// Instruction-select stage with prioritised interrupt injection.
//
// Chooses between internal and external instruction ROM bytes, holds operand
// bytes while the decoder stalls, and substitutes an LCALL to the vector of
// the highest eligible pending interrupt level. In-service levels are tracked
// so only strictly higher-priority requests can nest; RETI retires the
// highest in-service level.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rd                       decoder consumes current instruction
//   ea, ea_int               external-access pin, internal ROM range flag
//   istb / istb_o            fetch strobe in / strobe to external ROM
//   iack_i                   external ROM data valid
//   op1_i..op3_i             internal ROM bytes
//   op1_x..op3_x             external ROM bytes
//   intr, int_v              per-level request and vector (level k at k*VEC_W)
//   reti                     decoder executed RETI
//   op1_out..op3_out         instruction bytes to decoder/PC
//   op2_direct               direct-address byte (SFR remap applied)
//   ack                      one-cycle per-level acknowledge
//   in_service               currently serviced levels
module oc8051_op_select_pri #(
  parameter int unsigned INT_LEVELS = 2,
  parameter int unsigned VEC_W      = 8,
  parameter logic [7:0]  NOP_OP     = 8'h00
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rd,
  input  logic                        ea,
  input  logic                        ea_int,
  input  logic                        istb,
  output logic                        istb_o,
  input  logic                        iack_i,
  input  logic [7:0]                  op1_i,
  input  logic [7:0]                  op2_i,
  input  logic [7:0]                  op3_i,
  input  logic [7:0]                  op1_x,
  input  logic [7:0]                  op2_x,
  input  logic [7:0]                  op3_x,
  input  logic [INT_LEVELS-1:0]       intr,
  input  logic [INT_LEVELS*VEC_W-1:0] int_v,
  input  logic                        reti,
  output logic [7:0]                  op1_out,
  output logic [7:0]                  op2_out,
  output logic [7:0]                  op3_out,
  output logic [7:0]                  op2_direct,
  output logic [INT_LEVELS-1:0]       ack,
  output logic [INT_LEVELS-1:0]       in_service
);

  localparam int unsigned IdxW = (INT_LEVELS > 1) ? $clog2(INT_LEVELS) : 1;
  localparam logic [7:0]  LcallOp = 8'h12;

  logic [INT_LEVELS-1:0] r_pend;
  logic [VEC_W-1:0]      r_vec [INT_LEVELS];
  logic [INT_LEVELS-1:0] r_in_service;
  logic [INT_LEVELS-1:0] r_ack;
  logic [7:0]            r_op2;
  logic [7:0]            r_op3;
  logic [7:0]            r_op2_direct;

  logic                  w_sel;
  logic                  w_inst_valid;
  logic [7:0]            w_raw1, w_raw2, w_raw3;
  logic [7:0]            w_op1, w_op2, w_op3;
  logic [7:0]            w_direct;
  logic                  w_isr_any;
  logic [IdxW-1:0]       w_isr_top;
  logic                  w_inj;
  logic [IdxW-1:0]       w_win;
  logic                  w_take;
  logic [INT_LEVELS-1:0] w_pend_d;
  logic [INT_LEVELS-1:0] w_isr_d;
  logic [INT_LEVELS-1:0] w_ack_d;

  assign w_sel        = ea & ea_int;
  assign istb_o       = w_sel ? 1'b0 : istb;
  assign w_inst_valid = w_sel | iack_i;

  always_comb begin
    if (w_sel) begin
      w_raw1 = op1_i;
      w_raw2 = op2_i;
      w_raw3 = op3_i;
    end else if (iack_i) begin
      w_raw1 = op1_x;
      w_raw2 = op2_x;
      w_raw3 = op3_x;
    end else begin
      w_raw1 = NOP_OP;
      w_raw2 = 8'h00;
      w_raw3 = 8'h00;
    end
  end

  // Highest in-service level and highest eligible pending level.
  always_comb begin
    w_isr_any = |r_in_service;
    w_isr_top = '0;
    w_inj     = 1'b0;
    w_win     = '0;
    for (int k = 0; k < INT_LEVELS; k++) begin
      if (r_in_service[k]) w_isr_top = IdxW'(k);
    end
    for (int k = 0; k < INT_LEVELS; k++) begin
      if (r_pend[k] && (!w_isr_any || (IdxW'(k) > w_isr_top))) begin
        w_inj = 1'b1;
        w_win = IdxW'(k);
      end
    end
  end

  always_comb begin
    if (w_inj && w_inst_valid) begin
      w_op1 = LcallOp;
      w_op2 = 8'h00;
      w_op3 = 8'(r_vec[w_win]);
    end else begin
      w_op1 = w_raw1;
      w_op2 = w_raw2;
      w_op3 = w_raw3;
    end
  end

  // Opcodes whose direct operand is implicitly DPL or B.
  always_comb begin
    case (w_op1)
      8'h90, 8'hA3, 8'h73, 8'h93: w_direct = 8'h82;
      8'hA4, 8'h84:               w_direct = 8'hF0;
      default:                    w_direct = w_op2;
    endcase
  end

  assign op1_out    = w_op1;
  assign op2_out    = rd ? w_op2 : r_op2;
  assign op3_out    = rd ? w_op3 : r_op3;
  assign op2_direct = rd ? w_direct : r_op2_direct;
  assign ack        = r_ack;
  assign in_service = r_in_service;

  // A new request on the winning level beats its clear; RETI acts on the
  // pre-injection in-service value.
  always_comb begin
    w_take   = rd & w_inj & w_inst_valid;
    w_pend_d = r_pend;
    w_isr_d  = r_in_service;
    w_ack_d  = '0;
    if (w_take) w_pend_d[w_win] = 1'b0;
    w_pend_d = w_pend_d | intr;
    if (reti && w_isr_any) w_isr_d[w_isr_top] = 1'b0;
    if (w_take) begin
      w_isr_d[w_win] = 1'b1;
      w_ack_d[w_win] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend       <= '0;
      r_in_service <= '0;
      r_ack        <= '0;
      r_op2        <= 8'h00;
      r_op3        <= 8'h00;
      r_op2_direct <= 8'h00;
      for (int k = 0; k < INT_LEVELS; k++) r_vec[k] <= '0;
    end else begin
      r_pend       <= w_pend_d;
      r_in_service <= w_isr_d;
      r_ack        <= w_ack_d;
      for (int k = 0; k < INT_LEVELS; k++) begin
        if (intr[k]) r_vec[k] <= int_v[k*VEC_W +: VEC_W];
      end
      if (rd) begin
        r_op2        <= w_op2;
        r_op3        <= w_op3;
        r_op2_direct <= w_direct;
      end
    end
  end

endmodule
